// File: rtl/uart_word_tx.sv
// uart_word_tx: accepts a 32-bit word and sends it as four back-to-back 8N1 UART frames.
// Define UART_WORD_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_word_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter bit MSB_BYTE_1ST = 1'b0
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic [31:0] word_data,
   input  logic        word_valid,
   output logic        word_ready,
   output logic        busy,
   output logic        TX
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_WORD_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t            state, state_next;
   logic [BAUD_W-1:0] baud_cnt, baud_next;
   logic [2:0]        bit_cnt, bit_next;
   logic [1:0]        byte_cnt, byte_next;
   logic [31:0]       shift_reg, shift_next;
   logic              bit_done;

   always_ff @(posedge CLK) begin
      if (rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         byte_cnt  <= '0;
         shift_reg <= '0;
      end else begin
         state     <= state_next;
         baud_cnt  <= baud_next;
         bit_cnt   <= bit_next;
         byte_cnt  <= byte_next;
         shift_reg <= shift_next;
      end
   end

   assign bit_done = (baud_cnt == BAUD_LAST);

   // The shift register rotates rather than shifts, so after eight data bits the
   // byte just sent sits in [31:24] (for parity) and the next byte is in [7:0].
   always_comb begin
      state_next = state;
      baud_next  = baud_cnt;
      bit_next   = bit_cnt;
      byte_next  = byte_cnt;
      shift_next = shift_reg;
      if (state != IDLE) begin
         baud_next = bit_done ? '0 : baud_cnt + 1'b1;
      end
      case (state)
         IDLE: begin
            if (word_valid) begin
               state_next = START;
               baud_next  = '0;
               bit_next   = '0;
               byte_next  = '0;
               shift_next = MSB_BYTE_1ST ?
                  {word_data[7:0], word_data[15:8], word_data[23:16], word_data[31:24]} :
                  word_data;
            end
         end
         START: begin
            if (bit_done) state_next = DATA;
         end
         DATA: begin
            if (bit_done) begin
               shift_next = {shift_reg[0], shift_reg[31:1]};
               bit_next   = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef UART_WORD_TX_PARITY_EN
         PARITY: begin
            if (bit_done) state_next = STOP;
         end
`endif
         STOP: begin
            if (bit_done) begin
               if (byte_cnt == 2'd3) begin
                  state_next = IDLE;
                  byte_next  = '0;
               end else begin
                  state_next = START;
                  byte_next  = byte_cnt + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The line level is a pure decode of state and shift register.
   always_comb begin
      TX = 1'b1;
      case (state)
         START:   TX = 1'b0;
         DATA:    TX = shift_reg[0];
`ifdef UART_WORD_TX_PARITY_EN
         PARITY:  TX = ^shift_reg[31:24];
`endif
         default: TX = 1'b1;
      endcase
   end

   assign word_ready = (state == IDLE);
   assign busy       = ~word_ready;

endmodule
